// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader_if
// Purpose  : Byte-stream receive channel plus instruction-memory write port
//            of the boot loader, bundled for connection.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  im_we;
    logic [ADDR_WIDTH-1:0] im_addr;
    logic [31:0]           im_data;

    // Loader side: consumes the byte stream, drives the memory write port.
    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output im_we,
        output im_addr,
        output im_data
    );

    // Environment side: byte source and instruction memory.
    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  im_we,
        input  im_addr,
        input  im_data
    );
endinterface
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Holds the core in reset, loads a length-prefixed big-endian
//            word stream into instruction memory, then releases the core
//            after RELEASE_DELAY cycles. Start from RUN/ERR reloads.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_WIDTH    = 10,
    parameter int RELEASE_DELAY = 4
) (
    input  wire logic            clk_i,
    input  wire logic            rst_ni,
    input  wire logic            start_i,
    imem_boot_loader_if.master   bus,
    output logic                 core_reset_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int HCW   = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
        S_HOLD = 3'd4,
        S_RUN  = 3'd5,
        S_ERR  = 3'd6
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [ADDR_WIDTH:0]   widx_q, widx_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [HCW-1:0]        hcnt_q, hcnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  core_rst_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic                  w_ready;
    logic                  w_accept;
    logic [15:0]           w_len;
    logic [31:0]           w_word;
    logic [ADDR_WIDTH:0]   w_widx_inc;

    assign w_ready    = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
    assign w_accept   = w_ready && bus.rx_valid;
    assign w_len      = {n_q[15:8], bus.rx_data};
    // The three earlier bytes of the word sit in the assembler, MSB first.
    assign w_word     = {asm_q, bus.rx_data};
    assign w_widx_inc = widx_q + 1'b1;

    // Next-state and datapath decisions for the load sequence.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        widx_d  = widx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        hcnt_d  = hcnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start_i) begin
                    state_d = S_HDR0;
                end
            end
            S_HDR0: begin
                if (w_accept) begin
                    n_d[15:8] = bus.rx_data;
                    state_d   = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_accept) begin
                    n_d = w_len;
                    if (w_len == 16'd0) begin
                        hcnt_d  = '0;
                        state_d = S_HOLD;
                    end else if ({16'd0, w_len} > 32'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        widx_d  = '0;
                        bcnt_d  = 2'd0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    asm_d  = w_word[23:0];
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d   = 1'b1;
                        addr_d = widx_q[ADDR_WIDTH-1:0];
                        data_d = w_word;
                        widx_d = w_widx_inc;
                        if (32'(w_widx_inc) == {16'd0, n_q}) begin
                            hcnt_d  = '0;
                            state_d = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (hcnt_q == HCW'(RELEASE_DELAY - 1)) begin
                    state_d = S_RUN;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and state-derived status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            widx_q     <= '0;
            bcnt_q     <= '0;
            asm_q      <= '0;
            hcnt_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            widx_q     <= widx_d;
            bcnt_q     <= bcnt_d;
            asm_q      <= asm_d;
            hcnt_q     <= hcnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            core_rst_q <= (state_d != S_RUN);
            busy_q     <= (state_d == S_HDR0) || (state_d == S_HDR1) ||
                          (state_d == S_DATA) || (state_d == S_HOLD);
            done_q     <= (state_d == S_RUN);
            err_q      <= (state_d == S_ERR);
        end
    end

    assign bus.rx_ready = w_ready;
    assign bus.im_we    = we_q;
    assign bus.im_addr  = addr_q;
    assign bus.im_data  = data_q;
    assign core_reset_o = core_rst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Self-checking bench for imem_boot_loader with a byte-count based
//            reference model and randomized stream pacing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;
    localparam int AW    = 10;
    localparam int RD    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic core_reset, busy, done, err;

    imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW), .RELEASE_DELAY(RD)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .bus          (bus),
        .core_reset_o (core_reset),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: progress measured in accepted bytes.
    bit        m_loading, m_holding, m_running, m_errored, m_we;
    int        m_count, m_n, m_hold_left, m_addr;
    bit [31:0] m_word, m_data;

    task automatic model_reset();
        m_loading = 0; m_holding = 0; m_running = 0; m_errored = 0; m_we = 0;
        m_count = 0; m_n = 0; m_hold_left = 0; m_addr = 0;
        m_word = '0; m_data = '0;
    endtask

    task automatic model_step();
        int k;
        m_we = 0;
        if (m_holding) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_holding = 0;
                m_running = 1;
            end
        end else if (m_loading) begin
            if (bus.rx_valid) begin
                if (m_count == 0) begin
                    m_n = int'(bus.rx_data) * 256;
                end else if (m_count == 1) begin
                    m_n = m_n + int'(bus.rx_data);
                    if (m_n == 0) begin
                        m_loading = 0; m_holding = 1; m_hold_left = RD;
                    end else if (m_n > DEPTH) begin
                        m_loading = 0; m_errored = 1;
                    end
                end else begin
                    k = m_count - 2;
                    m_word = {m_word[23:0], bus.rx_data};
                    if (k % 4 == 3) begin
                        m_we = 1; m_addr = k / 4; m_data = m_word;
                        if (k / 4 + 1 == m_n) begin
                            m_loading = 0; m_holding = 1; m_hold_left = RD;
                        end
                    end
                end
                m_count++;
            end
        end else if (start) begin
            m_loading = 1; m_count = 0; m_running = 0; m_errored = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        logic [AW+37:0] exp_v, act_v;
        int             ma;
        forever begin
            @(negedge clk);
            ma    = m_addr;
            exp_v = {m_loading, m_we, ma[AW-1:0], m_data, ~m_running,
                     (m_loading | m_holding), m_running, m_errored};
            act_v = {bus.rx_ready, bus.im_we, bus.im_addr, bus.im_data, core_reset,
                     busy, done, err};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL cycle t=%0t rdy/we/addr/data/cr/busy/done/err got %b/%b/%h/%h/%b/%b/%b/%b want %b/%b/%h/%h/%b/%b/%b/%b",
                             $time, bus.rx_ready, bus.im_we, bus.im_addr, bus.im_data, core_reset, busy, done, err,
                             m_loading, m_we, ma[AW-1:0], m_data, ~m_running, m_loading | m_holding, m_running, m_errored);
            end
        end
    end

    // Log of writes seen on the memory port.
    int          w_addr[$];
    logic [31:0] w_data[$];
    initial begin
        forever begin
            @(negedge clk);
            if (bus.im_we === 1'b1) begin
                w_addr.push_back(int'(bus.im_addr));
                w_data.push_back(bus.im_data);
            end
        end
    end

    logic [7:0]  bq[$];
    logic [31:0] wq[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic build_stream(input int n);
        logic [31:0] w;
        logic [15:0] nn;
        nn = 16'(n);
        bq.delete();
        bq.push_back(nn[15:8]);
        bq.push_back(nn[7:0]);
        foreach (wq[i]) begin
            w = wq[i];
            bq.push_back(w[31:24]); bq.push_back(w[23:16]);
            bq.push_back(w[15:8]);  bq.push_back(w[7:0]);
        end
    endtask

    // mode 0: valid held high; 1: valid every other cycle; 2: random gaps + start noise.
    task automatic send(input int mode);
        bit   ph = 0;
        bit   v, rdy, acc;
        int   t;
        for (int i = 0; i < bq.size(); i++) begin
            acc = 0; t = 0;
            while (!acc) begin
                @(negedge clk);
                ph = ~ph;
                v  = (mode == 0) ? 1'b1 : (mode == 1) ? ph : ($urandom_range(0, 3) != 0);
                bus.rx_valid = v;
                bus.rx_data  = v ? bq[i] : 8'($urandom);
                start        = (mode == 2) && (i < bq.size() - 1) && ($urandom_range(0, 7) == 0);
                rdy          = bus.rx_ready;
                @(posedge clk);
                if (v && rdy) acc = 1;
                t++;
                if (!acc && t > 200) begin
                    checks++; errors++;
                    $display("FAIL send_timeout byte %0d got no acceptance want acceptance", i);
                    return;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            start        = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // Counts clock edges from the last accepted byte until core reset drops.
    task automatic wait_release(output int n);
        n = 0;
        @(negedge clk);
        while (core_reset !== 1'b0 && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_writes(input string name);
        int bad = 0;
        chk({name, "_nwrites"}, w_addr.size(), wq.size());
        for (int i = 0; i < w_addr.size() && i < wq.size(); i++)
            if (w_addr[i] != i || w_data[i] !== wq[i]) bad++;
        chk({name, "_content"}, bad, 0);
    endtask

    initial begin
        int n;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;

        // Reset held with valid asserted.
        repeat (3) @(negedge clk);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_rx_ready", bus.rx_ready, 0);
        chk("rst_im_we", bus.im_we, 0);
        chk("rst_im_addr", bus.im_addr, 0);
        chk("rst_status", {busy, done, err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", {bus.rx_ready, busy, core_reset}, 3'b001);
        idle(1);

        // Basic three-word load.
        wq.delete();
        wq.push_back(32'h3C010010); wq.push_back(32'h34210004); wq.push_back(32'hAC010000);
        build_stream(3);
        w_addr.delete(); w_data.delete();
        pulse_start();
        send(0);
        wait_release(n);
        chk("basic_release_lat", n, RD);
        chk("basic_model_n", m_n, 3);
        chk("basic_nwrites", w_addr.size(), 3);
        if (w_addr.size() == 3) begin
            chk("basic_w0", {w_addr[0], w_data[0]}, {32'd0, 32'h3C010010});
            chk("basic_w1", {w_addr[1], w_data[1]}, {32'd1, 32'h34210004});
            chk("basic_w2", {w_addr[2], w_data[2]}, {32'd2, 32'hAC010000});
        end
        chk("basic_done_busy", {done, busy}, 2'b10);

        // Reload from RUN: core back in reset on the next edge.
        pulse_start();
        chk("reload_core_reset", core_reset, 1);
        chk("reload_done", done, 0);

        // Same stream, alternating valid.
        w_addr.delete(); w_data.delete();
        send(1);
        wait_release(n);
        chk("bp_release_lat", n, RD);
        check_writes("bp");

        // Empty program.
        wq.delete();
        build_stream(0);
        w_addr.delete(); w_data.delete();
        pulse_start();
        send(0);
        wait_release(n);
        chk("empty_release_lat", n, RD);
        chk("empty_nwrites", w_addr.size(), 0);

        // Overflow header.
        bq.delete(); bq.push_back(8'h04); bq.push_back(8'h01);
        w_addr.delete(); w_data.delete();
        pulse_start();
        send(0);
        repeat (5) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
        end
        chk("ovf_err", err, 1);
        chk("ovf_rx_ready", bus.rx_ready, 0);
        chk("ovf_core_reset", core_reset, 1);
        chk("ovf_nwrites", w_addr.size(), 0);

        // Full-capacity load.
        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
        build_stream(DEPTH);
        w_addr.delete(); w_data.delete();
        pulse_start();
        chk("full_err_cleared", err, 0);
        send(0);
        wait_release(n);
        check_writes("full");
        chk("full_last_addr", w_addr.size() > 0 ? w_addr[w_addr.size()-1] : -1, DEPTH - 1);
        chk("full_done", done, 1);

        // Reset after two data bytes.
        wq.delete(); wq.push_back(32'hDEADBEEF);
        build_stream(1);
        void'(bq.pop_back()); void'(bq.pop_back());
        pulse_start();
        send(0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {core_reset, bus.rx_ready, bus.im_we, busy, done, err}, 6'b100000);
        chk("midrst_addr_data", {bus.im_addr, bus.im_data}, 0);
        rst_n = 1'b1;
        idle(2);
        wq.delete(); wq.push_back(32'h12345678);
        build_stream(1);
        w_addr.delete(); w_data.delete();
        pulse_start();
        send(0);
        wait_release(n);
        check_writes("after_rst");

        // Random programs with random pacing and ignored start noise.
        for (int r = 0; r < 8; r++) begin
            int nw = (r == 3) ? 0 : int'($urandom_range(1, 8));
            wq.delete();
            for (int i = 0; i < nw; i++) wq.push_back($urandom);
            build_stream(nw);
            w_addr.delete(); w_data.delete();
            pulse_start();
            send(2);
            wait_release(n);
            chk("rand_release_lat", n, RD);
            check_writes("rand");
            idle(int'($urandom_range(0, 3)));
        end

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time program loader sitting directly upstream of the MIPS core. Holds the core in reset, receives a length-prefixed byte stream over a valid/ready interface, and assembles 32-bit big-endian instruction words. It writes those words into instruction memory through a single write port, then releases the core's reset after a programmable delay. A later Start reasserts core reset and reloads.

## Interface
- ADDR_WIDTH, 10: instruction-memory word-address width; capacity DEPTH = 2^ADDR_WIDTH words.
- RELEASE_DELAY, 4: cycles spent in HOLD before core reset is released (≥1).

- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-low block reset.
- Start  in  1  begin a load; sampled only in IDLE, RUN, ERR.
- RxData  in  8  stream byte.
- RxValid  in  1  RxData valid.
- RxReady  out  1  loader accepts a byte; transfer on rising edge with RxValid&&RxReady.
- ImWe  out  1  instruction-memory write strobe, one cycle per word.
- ImAddr  out  ADDR_WIDTH  word address.
- ImData  out  32  word to write.
- CoreReset  out  1  active-high reset to the core, registered.
- Busy  out  1  high in HDR0, HDR1, DATA, HOLD.
- Done  out  1  high in RUN.
- Err  out  1  high in ERR.

## Operation
- Stream format: 2-byte big-endian word count N, then N words of 4 bytes each, MSB first.
- States: IDLE, HDR0, HDR1, DATA, HOLD, RUN, ERR.
- IDLE: CoreReset=1. Start → HDR0.
- HDR0: accept byte → N[15:8]; → HDR1.
- HDR1: accept byte → N[7:0]. Next state:
  - N==0 → HOLD.
  - N>DEPTH → ERR.
  - otherwise → DATA, with word index and byte counter cleared.
- DATA: accept bytes, shifting into a 32-bit assembler.
  - On the 4th byte, ImWe=1 next cycle with ImAddr=word index and ImData=assembled word.
  - Word index increments; byte counter wraps 3→0.
  - After the 4th byte of word N-1 → HOLD.
- HOLD: counter runs 0..RELEASE_DELAY-1, then → RUN.
- RUN: CoreReset=0, Done=1. Start → HDR0, with CoreReset=1 and Done=0 from the next edge.
- ERR: CoreReset=1, Err=1. Start → HDR0 and clears Err. No memory writes occur in ERR.
- RxReady is decoded from state: 1 only in HDR0, HDR1, DATA.
- Start is ignored in HDR0, HDR1, DATA, HOLD.
- The write port does not stall the stream: a new byte may be accepted in the same cycle ImWe is high.
- Word index is ADDR_WIDTH+1 bits internally. ImAddr never wraps, since N≤DEPTH is guaranteed before DATA.

## Timing
- Reset asserted (Reset=0), immediately and asynchronously:
  - state=IDLE.
  - CoreReset=1.
  - ImWe=0, ImAddr=0, ImData=0.
  - Busy=0, Done=0, Err=0, RxReady=0.
  - Assembler, counters and N cleared.
- Reset mid-load (any state): same as above. Memory contents are not restored; a new Start is required.
- Byte acceptance: one byte per cycle maximum. RxValid gaps simply stall progress, with no timeout.
- Write latency: ImWe is high exactly one cycle, in the cycle following the edge that accepted the word's 4th byte. ImAddr/ImData hold their values after the write.
- Release latency: CoreReset falls at the edge RELEASE_DELAY cycles after the edge that moved to HOLD.
  - The last word's ImWe precedes core release by ≥1 cycle.
- Done/Err/Busy are registered with the state, changing on the same edges as the state transitions.

## Test plan
- Reset: hold Reset=0 for 3 cycles with RxValid=1 → CoreReset=1, RxReady=0, ImWe=0, ImAddr=0, Busy/Done/Err=0. Release → still IDLE.
- Basic load (RELEASE_DELAY=4):
  - Stimulus: Start pulse, stream 00 03 | 3C 01 00 10 | 34 21 00 04 | AC 01 00 00 with RxValid held high.
  - ImWe pulses three times: (0, 3C010010), (1, 34210004), (2, AC010000).
  - CoreReset falls 4 cycles after the last byte is accepted; Done=1, Busy=0.
- Backpressure: same stream with RxValid low every other cycle → identical writes and data; no byte is dropped or duplicated.
- Empty program: stream 00 00 → no ImWe; HOLD then RUN; CoreReset falls RELEASE_DELAY cycles after the 2nd byte.
- Overflow, ADDR_WIDTH=10:
  - Stream 04 01 → ERR, Err=1, RxReady=0, no ImWe, CoreReset stays 1.
  - Start, then stream 04 00 and 1024 words → writes at addresses 0..1023, ImAddr does not wrap, Done=1.
- Reload and mid-load reset:
  - In RUN, pulse Start → CoreReset=1 next cycle, Done=0.
  - Assert Reset after 2 data bytes → all outputs return to reset values.
  - Then Start plus a 1-word stream → single write at address 0.
